// File: rtl/rr_arb_pkg.sv
// Shared types and sizes for the 32-way round-robin resource arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package rr_arb_pkg;

  localparam int N_REQ  = 32;
  localparam int WDOG_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/lsb_first_encoder32.sv
// LSB-first priority encoder: index of the lowest set bit of a 32-bit vector.
// Latency: purely combinational.
// Backpressure: none; index is 0 and any_set is low for an all-zero input.
module lsb_first_encoder32
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] data,
  output logic [4:0]       index,
  output logic             any_set
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (data[i]) index = 5'(i);
    end
    any_set = |data;
  end

endmodule

// File: rtl/rr_arbiter32.sv
// Round-robin arbiter granting one of 32 requesters ownership of a shared resource.
// Latency: grant/res_valid 1 cycle after req; release 1 cycle after res_done or watchdog expiry.
// Backpressure: res_valid and grant hold until res_ready; ownership holds until res_done or timeout.
module rr_arbiter32
  import rr_arb_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int IDX_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              res_valid,
  input  logic              res_ready,
  input  logic              res_done,
  output logic              busy,
  output logic              timeout_err
);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  logic [N_REQ-1:0]  grant_d;
  logic [IDX_W-1:0]  grant_idx_d;
  logic              res_valid_d;
  logic              busy_d;
  logic              timeout_err_d;

  logic [N_REQ-1:0]  masked;
  logic [IDX_W-1:0]  m_idx, r_idx, sel;
  logic              m_any, r_any;
  logic              done_evt, wdog_evt, release_evt;

  // Requesters at or above the pointer get first pick; below it only on wrap.
  assign masked = req & ({N_REQ{1'b1}} << ptr_q);

  lsb_first_encoder32 u_enc_masked (
    .data    (masked),
    .index   (m_idx),
    .any_set (m_any)
  );

  lsb_first_encoder32 u_enc_req (
    .data    (req),
    .index   (r_idx),
    .any_set (r_any)
  );

  assign sel = m_any ? m_idx : r_idx;

  // res_done has priority over the watchdog when both land in the same cycle.
  assign done_evt    = (state_q == BUSY) && res_done;
  assign wdog_evt    = (state_q == BUSY) && !res_done && (wdog_q == WDOG_W'(TIMEOUT - 1));
  assign release_evt = done_evt || wdog_evt;

  // State, pointer, watchdog and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      wdog_q      <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wdog_q      <= wdog_d;
      grant       <= grant_d;
      grant_idx   <= grant_idx_d;
      res_valid   <= res_valid_d;
      busy        <= busy_d;
      timeout_err <= timeout_err_d;
    end
  end

  // Next-state transitions of the IDLE -> ISSUE -> BUSY -> IDLE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (r_any)       state_d = ISSUE;
      ISSUE:   if (res_ready)   state_d = BUSY;
      BUSY:    if (release_evt) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and watchdog.
  always_comb begin
    grant_d       = grant;
    grant_idx_d   = grant_idx;
    res_valid_d   = res_valid;
    busy_d        = busy;
    timeout_err_d = 1'b0;
    ptr_d         = ptr_q;
    wdog_d        = wdog_q;
    case (state_q)
      IDLE: begin
        if (r_any) begin
          grant_d     = N_REQ'(1) << sel;
          grant_idx_d = sel;
          res_valid_d = 1'b1;
          busy_d      = 1'b1;
        end else begin
          grant_d     = '0;
          grant_idx_d = '0;
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      ISSUE: begin
        // Grant is committed here; req changes and res_done are ignored.
        if (res_ready) begin
          res_valid_d = 1'b0;
          wdog_d      = '0;
        end
      end
      BUSY: begin
        wdog_d = wdog_q + 1'b1;
        if (release_evt) begin
          grant_d       = '0;
          grant_idx_d   = '0;
          busy_d        = 1'b0;
          ptr_d         = grant_idx + IDX_W'(1);
          timeout_err_d = wdog_evt;
          wdog_d        = '0;
        end
      end
      default: begin
        grant_d     = '0;
        grant_idx_d = '0;
        res_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter32.sv
// Directed testbench for rr_arbiter32 with a short watchdog.
// Latency: drives and samples on the falling clock edge.
// Backpressure: res_ready delay and res_done timing chosen per transaction.
module tb_rr_arbiter32;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] req;
  logic [31:0] grant;
  logic [4:0]  grant_idx;
  logic        res_valid;
  logic        res_ready;
  logic        res_done;
  logic        busy;
  logic        timeout_err;

  int n_checks = 0;
  int n_errors = 0;
  int last_lat = 0;

  rr_arbiter32 #(.TIMEOUT(TMO), .IDX_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_done    (res_done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for res_valid; lat counts falling edges until it appears.
  task automatic wait_grant(output int lat);
    lat = 0;
    repeat (8) begin
      @(negedge clk);
      lat++;
      if (res_valid) return;
    end
    check_val("grant_wait", 32'd0, 32'd1);
    lat = -1;
  endtask

  // One full transaction: expect exp_idx, accept after rdy_dly ISSUE cycles,
  // pulse res_done in BUSY cycle done_at (0 = never, watchdog releases).
  task automatic run_txn(input int exp_idx, input int rdy_dly, input int done_at);
    int lat;
    logic [31:0] g;
    wait_grant(lat);
    last_lat = lat;
    if (lat < 0) return;
    g = 32'd1 << exp_idx;
    check_val("grant_idx", 32'(grant_idx), 32'(exp_idx));
    check_val("grant_onehot", grant, g);
    check_val("busy_issue", 32'(busy), 32'd1);
    check_val("terr_low_issue", 32'(timeout_err), 32'd0);
    for (int c = 0; c <= rdy_dly; c++) begin
      if (c > 0) begin
        check_val("issue_grant_hold", grant, g);
        check_val("issue_valid_hold", 32'(res_valid), 32'd1);
      end
      res_ready = (c == rdy_dly);
      res_done  = (c == 0 && rdy_dly > 0);
      @(negedge clk);
    end
    res_ready = 1'b0;
    res_done  = 1'b0;
    for (int b = 1; b <= TMO; b++) begin
      check_val("busy_valid_low", 32'(res_valid), 32'd0);
      check_val("busy_grant_hold", grant, g);
      check_val("busy_flag", 32'(busy), 32'd1);
      res_done = (b == done_at);
      @(negedge clk);
      res_done = 1'b0;
      if (b == done_at || b == TMO) begin
        check_val("release_grant", grant, 32'd0);
        check_val("release_busy", 32'(busy), 32'd0);
        check_val("release_terr", 32'(timeout_err), (b == done_at) ? 32'd0 : 32'd1);
        return;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    // Reset with every requester active.
    rst_n = 1'b0; req = 32'hFFFF_FFFF; res_ready = 1'b0; res_done = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_grant", grant, 32'd0);
    check_val("rst_valid", 32'(res_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_idx", 32'(grant_idx), 32'd0);
    check_val("rst_terr", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    run_txn(0, 0, 1);
    check_val("first_latency", 32'(last_lat), 32'd1);

    // Idle with no requests keeps outputs low.
    req = 32'h0;
    repeat (3) @(negedge clk);
    check_val("idle_grant", grant, 32'd0);
    check_val("idle_valid", 32'(res_valid), 32'd0);

    // Two requesters: 4, then 10, then wrap back to 4.
    req = 32'h0000_0410;
    run_txn(4, 2, 3);
    run_txn(10, 0, 1);
    run_txn(4, 0, 1);

    // Fairness sweep from a fresh pointer.
    rst_n = 1'b0; req = 32'hFFFF_FFFF;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) run_txn(i, 0, 1);
    run_txn(0, 0, 1);

    // Pointer wrap from 31 to 0.
    req = 32'h4000_0000;
    run_txn(30, 1, 2);
    req = 32'h8000_0001;
    run_txn(31, 0, 1);
    run_txn(0, 0, 1);

    // Watchdog release, then res_done in the timeout cycle.
    req = 32'h0000_0008;
    run_txn(3, 0, 0);
    req = 32'h0000_0018;
    run_txn(4, 0, TMO);
    req = 32'h0000_0030;
    run_txn(5, 0, 1);

    // Asynchronous reset while busy with requester 7.
    req = 32'h0000_0080;
    wait_grant(lat);
    check_val("pre_rst_idx", 32'(grant_idx), 32'd7);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_val("pre_rst_busy", 32'(busy), 32'd1);
    check_val("pre_rst_grant", grant, 32'h0000_0080);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_grant", grant, 32'd0);
    check_val("async_idx", 32'(grant_idx), 32'd0);
    check_val("async_busy", 32'(busy), 32'd0);
    check_val("async_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    req = 32'h0000_0081;
    rst_n = 1'b1;
    run_txn(0, 0, 1);
    req = 32'h0000_0080;
    run_txn(7, 0, 1);
    req = 32'h0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
